// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin requester front end.
package arb_pkg;
    localparam int         N_REQ    = 4;
    localparam logic [2:0] GNT_NONE = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } issuer_state_t;
endpackage

// File: rtl/arb_client_slot.sv
// One client's transaction holding slot: payload register plus pending flag.
module arb_client_slot
    import arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_clear,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic          o_pending,
    output logic [DW-1:0] o_data
);

    logic          r_pending;
    logic [DW-1:0] r_data;

    // load and clear never coincide: load needs an empty slot, clear a full one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_data    <= '0;
        end else if (i_load) begin
            r_pending <= 1'b1;
            r_data    <= i_data;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end
    end

    assign o_ready   = !r_pending;
    assign o_pending = r_pending;
    assign o_data    = r_data;

endmodule

// File: rtl/rr_req_issuer.sv
// Requester front end: per-client slots, arbiter request/grant handling,
// single in-flight downstream issue and response routing with timeout.
module rr_req_issuer
    import arb_pkg::*;
#(
    parameter int DW          = 32,
    parameter int RW          = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  c_valid,
    output logic [N_REQ-1:0]  c_ready,
    input  logic [4*DW-1:0]   c_data,
    output logic              req0,
    output logic              req1,
    output logic              req2,
    output logic              req3,
    input  logic [2:0]        gnt_id,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [1:0]        m_id,
    input  logic              s_rsp_valid,
    input  logic [RW-1:0]     s_rsp_data,
    output logic [N_REQ-1:0]  c_rsp_valid,
    output logic [RW-1:0]     c_rsp_data,
    output logic              c_rsp_err
);

    localparam int             TW       = $clog2(RSP_TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(RSP_TIMEOUT - 1);

    issuer_state_t    r_state;
    issuer_state_t    w_next_state;
    logic [1:0]       r_cur_id;
    logic [TW-1:0]    r_tmo_cnt;
    logic             r_m_valid;
    logic [DW-1:0]    r_m_data;
    logic [1:0]       r_m_id;
    logic [N_REQ-1:0] r_c_rsp_valid;
    logic [RW-1:0]    r_c_rsp_data;
    logic             r_c_rsp_err;

    logic [N_REQ-1:0] w_pending;
    logic [N_REQ-1:0] w_load;
    logic [N_REQ-1:0] w_clear;
    logic [DW-1:0]    w_slot_data [N_REQ];
    logic [1:0]       w_gnt_idx;
    logic             w_idle;
    logic             w_in_wait;
    logic             w_issue;
    logic             w_accept;
    logic             w_rsp;
    logic             w_tmo;
    logic             w_done;
    logic [N_REQ-1:0] w_onehot;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        assign w_load[i]  = c_valid[i] && c_ready[i];
        assign w_clear[i] = w_done && (r_cur_id == 2'(i));

        arb_client_slot #(.DW(DW)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_load    (w_load[i]),
            .i_clear   (w_clear[i]),
            .i_data    (c_data[i*DW +: DW]),
            .o_ready   (c_ready[i]),
            .o_pending (w_pending[i]),
            .o_data    (w_slot_data[i])
        );
    end

    assign w_idle    = (r_state == IDLE);
    assign w_in_wait = (r_state == WAIT_RSP);
    assign w_gnt_idx = gnt_id[1:0];
    assign w_issue   = w_idle && (gnt_id < GNT_NONE) && w_pending[w_gnt_idx];
    assign w_accept  = (r_state == ISSUE) && r_m_valid && m_ready;
    // a real response beats a timeout landing on the same cycle
    assign w_rsp     = w_in_wait && s_rsp_valid;
    assign w_tmo     = w_in_wait && !s_rsp_valid && (r_tmo_cnt == TMO_LAST);
    assign w_done    = w_rsp || w_tmo;
    assign w_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << r_cur_id;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_issue)  w_next_state = ISSUE;
            ISSUE:    if (w_accept) w_next_state = WAIT_RSP;
            WAIT_RSP: if (w_done)   w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_id      <= '0;
            r_tmo_cnt     <= '0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_id        <= '0;
            r_c_rsp_valid <= '0;
            r_c_rsp_data  <= '0;
            r_c_rsp_err   <= 1'b0;
        end else begin
            r_c_rsp_valid <= '0;
            if (w_issue) begin
                r_cur_id  <= w_gnt_idx;
                r_m_id    <= w_gnt_idx;
                r_m_data  <= w_slot_data[w_gnt_idx];
                r_m_valid <= 1'b1;
            end
            if (w_accept) begin
                r_m_valid <= 1'b0;
            end
            if (w_in_wait && !w_done) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else                      r_tmo_cnt <= '0;
            if (w_done) begin
                r_c_rsp_valid <= w_onehot;
                r_c_rsp_data  <= w_rsp ? s_rsp_data : '0;
                r_c_rsp_err   <= !w_rsp;
            end
        end
    end

    assign req0        = w_pending[0] && w_idle;
    assign req1        = w_pending[1] && w_idle;
    assign req2        = w_pending[2] && w_idle;
    assign req3        = w_pending[3] && w_idle;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_id        = r_m_id;
    assign c_rsp_valid = r_c_rsp_valid;
    assign c_rsp_data  = r_c_rsp_data;
    assign c_rsp_err   = r_c_rsp_err;

endmodule

// File: tb/tb_rr_req_issuer.sv
// Self-checking bench for rr_req_issuer: transaction table plus hand-written
// corner sequences, with response expectations checked through a queue.
module tb_rr_req_issuer;

    localparam int DW  = 32;
    localparam int RW  = 32;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      c_valid;
    logic [3:0]      c_ready;
    logic [4*DW-1:0] c_data;
    logic            req0, req1, req2, req3;
    logic [2:0]      gnt_id;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic [1:0]      m_id;
    logic            s_rsp_valid;
    logic [RW-1:0]   s_rsp_data;
    logic [3:0]      c_rsp_valid;
    logic [RW-1:0]   c_rsp_data;
    logic            c_rsp_err;
    logic [3:0]      reqs;

    assign reqs = {req3, req2, req1, req0};

    rr_req_issuer #(.DW(DW), .RW(RW), .RSP_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .c_valid     (c_valid),
        .c_ready     (c_ready),
        .c_data      (c_data),
        .req0        (req0),
        .req1        (req1),
        .req2        (req2),
        .req3        (req3),
        .gnt_id      (gnt_id),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_id        (m_id),
        .s_rsp_valid (s_rsp_valid),
        .s_rsp_data  (s_rsp_data),
        .c_rsp_valid (c_rsp_valid),
        .c_rsp_data  (c_rsp_data),
        .c_rsp_err   (c_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    strobe;
        logic [RW-1:0] data;
        logic          err;
    } rsp_t;

    typedef struct {
        int            client;
        logic [DW-1:0] payload;
        int            stall;
        int            rspDelay;
        logic          tmo;
        logic [RW-1:0] rspData;
    } vec_t;

    rsp_t expq[$];
    rsp_t monE;
    vec_t vecs[6];
    int   total = 0;
    int   bad   = 0;
    logic monOn = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // every response strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (monOn && c_rsp_valid !== 4'b0000) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_rsp: got strobe %b expected none", c_rsp_valid);
            end else begin
                monE = expq.pop_front();
                checkOutput("rsp_strobe", 64'(c_rsp_valid), 64'(monE.strobe));
                checkOutput("rsp_data", 64'(c_rsp_data), 64'(monE.data));
                checkOutput("rsp_err", 64'(c_rsp_err), 64'(monE.err));
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        rsp_t e;
        logic [RW-1:0] expData;
        expData  = v.tmo ? '0 : v.rspData;
        e.strobe = 4'b0001 << v.client;
        e.data   = expData;
        e.err    = v.tmo;

        c_data[v.client*DW +: DW] = v.payload;
        c_valid[v.client] = 1'b1;
        step();
        c_valid = '0;
        checkOutput("slot_held", 64'(c_ready[v.client]), 64'd0);
        checkOutput("req_idle", 64'(reqs), 64'(4'b0001 << v.client));

        gnt_id = 3'(v.client);
        step();
        gnt_id = 3'd4;
        checkOutput("m_valid_issue", 64'(m_valid), 64'd1);
        checkOutput("m_id_issue", 64'(m_id), 64'(v.client));
        checkOutput("m_data_issue", 64'(m_data), 64'(v.payload));
        checkOutput("req_issue", 64'(reqs), 64'd0);

        for (int s = 0; s < v.stall; s++) begin
            step();
            checkOutput("m_valid_stall", 64'(m_valid), 64'd1);
            checkOutput("m_data_stall", 64'(m_data), 64'(v.payload));
            checkOutput("m_id_stall", 64'(m_id), 64'(v.client));
            checkOutput("req_stall", 64'(reqs), 64'd0);
        end

        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        checkOutput("m_valid_drop", 64'(m_valid), 64'd0);

        if (v.tmo) begin
            expq.push_back(e);
            for (int k = 1; k <= TMO; k++) begin
                step();
                if (k < TMO) checkOutput("no_early_tmo", 64'(c_rsp_valid), 64'd0);
            end
        end else begin
            for (int k = 0; k < v.rspDelay; k++) begin
                step();
                checkOutput("no_early_rsp", 64'(c_rsp_valid), 64'd0);
            end
            expq.push_back(e);
            s_rsp_valid = 1'b1;
            s_rsp_data  = v.rspData;
            step();
            s_rsp_valid = 1'b0;
            s_rsp_data  = $urandom;
        end
        checkOutput("rsp_now", 64'(c_rsp_valid), 64'(e.strobe));
        checkOutput("slot_freed", 64'(c_ready), 64'hF);

        step();
        checkOutput("rsp_one_cycle", 64'(c_rsp_valid), 64'd0);
        checkOutput("rsp_data_hold", 64'(c_rsp_data), 64'(expData));
        checkOutput("rsp_err_hold", 64'(c_rsp_err), 64'(v.tmo));
        checkOutput("queue_drained", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rsp_t e;
        vecs[0] = '{client: 2, payload: 32'hA5A5_0002, stall: 0, rspDelay: 0, tmo: 1'b0, rspData: 32'h0000_1234};
        vecs[1] = '{client: 2, payload: 32'hA5A5_0002, stall: 5, rspDelay: 0, tmo: 1'b0, rspData: 32'h0000_1234};
        vecs[2] = '{client: 2, payload: 32'hA5A5_0002, stall: 0, rspDelay: 0, tmo: 1'b1, rspData: 32'h0};
        vecs[3] = '{client: 0, payload: 32'hDEAD_0000, stall: 1, rspDelay: 3, tmo: 1'b0, rspData: 32'hBEEF_0001};
        vecs[4] = '{client: 3, payload: 32'h3333_3333, stall: 2, rspDelay: 7, tmo: 1'b0, rspData: 32'hFFFF_FFFF};
        vecs[5] = '{client: 1, payload: 32'h0000_0001, stall: 0, rspDelay: 0, tmo: 1'b1, rspData: 32'h0};

        rst         = 1'b1;
        c_valid     = '0;
        c_data      = '0;
        gnt_id      = 3'd4;
        m_ready     = 1'b0;
        s_rsp_valid = 1'b0;
        s_rsp_data  = '0;

        repeat (3) step();
        checkOutput("rst_c_ready", 64'(c_ready), 64'hF);
        checkOutput("rst_reqs", 64'(reqs), 64'd0);
        checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_m_id", 64'(m_id), 64'd0);
        checkOutput("rst_m_data", 64'(m_data), 64'd0);
        checkOutput("rst_rsp_valid", 64'(c_rsp_valid), 64'd0);
        checkOutput("rst_rsp_data", 64'(c_rsp_data), 64'd0);
        checkOutput("rst_rsp_err", 64'(c_rsp_err), 64'd0);
        rst   = 1'b0;
        monOn = 1'b1;

        s_rsp_valid = 1'b1;
        s_rsp_data  = 32'h5555_AAAA;
        step();
        s_rsp_valid = 1'b0;
        checkOutput("idle_rsp_dropped", 64'(c_rsp_valid), 64'd0);
        checkOutput("idle_rsp_data", 64'(c_rsp_data), 64'd0);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        c_data[0*DW +: DW] = 32'h0000_C0DE;
        c_valid[0] = 1'b1;
        step();
        c_valid = '0;
        gnt_id = 3'd3;
        step();
        checkOutput("gnt_nonpending", 64'(m_valid), 64'd0);
        checkOutput("gnt_nonpending_req", 64'(reqs), 64'd1);
        gnt_id = 3'd7;
        step();
        checkOutput("gnt_seven", 64'(m_valid), 64'd0);
        gnt_id = 3'd0;
        step();
        gnt_id = 3'd4;
        checkOutput("gnt_zero_valid", 64'(m_valid), 64'd1);
        checkOutput("gnt_zero_id", 64'(m_id), 64'd0);
        checkOutput("gnt_zero_data", 64'(m_data), 64'h0000_C0DE);

        c_data[1*DW +: DW] = 32'h1111_0001;
        c_valid[1] = 1'b1;
        step();
        c_valid = '0;
        checkOutput("load_in_issue", 64'(c_ready), 64'b1100);
        checkOutput("no_req_in_issue", 64'(reqs), 64'd0);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        e = '{strobe: 4'b0001, data: 32'h0000_7777, err: 1'b0};
        expq.push_back(e);
        s_rsp_valid = 1'b1;
        s_rsp_data  = 32'h0000_7777;
        step();
        s_rsp_valid = 1'b0;
        checkOutput("other_req_after", 64'(reqs), 64'b0010);
        checkOutput("other_ready_after", 64'(c_ready), 64'b1101);

        gnt_id = 3'd1;
        step();
        gnt_id = 3'd4;
        checkOutput("second_issue_id", 64'(m_id), 64'd1);
        checkOutput("second_issue_data", 64'(m_data), 64'h1111_0001);
        c_data[3*DW +: DW] = 32'h3000_0003;
        c_valid[3] = 1'b1;
        m_ready = 1'b1;
        step();
        c_valid = '0;
        m_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_rsp_valid = 1'b1;
        s_rsp_data  = 32'hDEAD_BEEF;
        step();
        s_rsp_valid = 1'b0;
        checkOutput("rst_mid_no_rsp", 64'(c_rsp_valid), 64'd0);
        checkOutput("rst_mid_ready", 64'(c_ready), 64'hF);
        checkOutput("rst_mid_reqs", 64'(reqs), 64'd0);
        checkOutput("rst_mid_m_valid", 64'(m_valid), 64'd0);
        step();
        checkOutput("rst_mid_still_quiet", 64'(c_rsp_valid), 64'd0);
        checkOutput("final_queue_empty", 64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
